// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, FSM states, ALU codes, IR field positions
// Imported by instr_decode and control_unit.
package cpu_pkg;

  localparam int IR_MSB    = 31;
  localparam int OP_LSB    = 27;
  localparam int RA_LSB    = 23;
  localparam int RB_LSB    = 19;
  localparam int RC_LSB    = 15;
  localparam int FIELD_LSB = 15;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ROR  = 5'b01001;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    ALU_PASS, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
    ALU_SHR, ALU_SHL, ALU_ROR, ALU_ROL
  } alu_op_e;

  typedef enum logic [2:0] {
    CL_RTYPE, CL_LD, CL_ST, CL_NOP, CL_HALT, CL_ILLEGAL
  } iclass_e;

endpackage

// File: rtl/instr_decode.sv
// instr_decode: opcode -> instruction class and ALU function
// Ports: opcode in; cls, alu_op out. Purely combinational.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [4:0] opcode,
  output iclass_e    cls,
  output alu_op_e    alu_op
);

  always_comb begin
    cls    = CL_ILLEGAL;
    alu_op = ALU_PASS;
    unique case (1'b1)
      (opcode >= OP_ADD && opcode <= OP_ROL): begin
        cls    = CL_RTYPE;
        // R-type opcodes are contiguous and map 1:1 onto ALU_ADD..ALU_ROL
        alu_op = alu_op_e'(4'(opcode - OP_ADD) + 4'(ALU_ADD));
      end
      (opcode == OP_LD):   cls = CL_LD;
      (opcode == OP_ST):   cls = CL_ST;
      (opcode == OP_NOP):  cls = CL_NOP;
      (opcode == OP_HALT): cls = CL_HALT;
      default:             cls = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired T0-T7 strobe sequencer for the single-bus CPU.
// Ports: clock, clear (async high), run, ir, mem_ready in; datapath
// strobes, reg selects, alu_op, halted, illegal out.
// Option: CONTROL_UNIT_MEM_WAIT_EN stretches T1/ld T6/st T7 until mem_ready.
module control_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_SEL_W = 4
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 run,
  input  logic [DATA_W-1:0]    ir,
  input  logic                 mem_ready,
  output logic                 pco,
  output logic                 pci,
  output logic                 incpc,
  output logic                 mari,
  output logic                 mdri,
  output logic                 mdro,
  output logic                 mdr_read,
  output logic                 iri,
  output logic                 ryi,
  output logic                 zi,
  output logic                 zlowo,
  output logic                 co,
  output logic                 rd,
  output logic                 wr,
  output logic                 reg_out_en,
  output logic                 reg_in_en,
  output logic [REG_SEL_W-1:0] reg_out_sel,
  output logic [REG_SEL_W-1:0] reg_in_sel,
  output logic [3:0]           alu_op,
  output logic                 halted,
  output logic                 illegal
);

  state_e state_q, state_d;
  logic [IR_MSB:FIELD_LSB] ir_q, ir_d;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  iclass_e    cls;
  alu_op_e    alu_r;
  logic       mem_go;
  logic       unused_ir;

  assign op = ir_q[OP_LSB +: 5];
  assign ra = ir_q[RA_LSB +: 4];
  assign rb = ir_q[RB_LSB +: 4];
  assign rc = ir_q[RC_LSB +: 4];

  // Low IR bits only matter to the datapath's C sign-extender
  assign unused_ir = ^{ir[FIELD_LSB-1:0], mem_ready};

`ifdef CONTROL_UNIT_MEM_WAIT_EN
  assign mem_go = mem_ready;
`else
  assign mem_go = 1'b1;
`endif

  instr_decode u_dec (
    .opcode (op),
    .cls    (cls),
    .alu_op (alu_r)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   if (mem_go) state_d = S_T2;
      S_T2: begin
        // shadow copy taken with the IR load; held to end of instruction
        ir_d    = ir[IR_MSB:FIELD_LSB];
        state_d = S_T3;
      end
      S_T3: begin
        case (cls)
          CL_RTYPE, CL_LD, CL_ST: state_d = S_T4;
          CL_HALT:                state_d = S_HALT;
          default:                state_d = S_T0;
        endcase
      end
      S_T4: state_d = S_T5;
      S_T5: state_d = (cls == CL_RTYPE) ? S_T0 : S_T6;
      S_T6: begin
        if (cls != CL_LD || mem_go) state_d = S_T7;
      end
      S_T7: begin
        if (cls != CL_ST || mem_go) state_d = S_T0;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    pco         = 1'b0;
    pci         = 1'b0;
    incpc       = 1'b0;
    mari        = 1'b0;
    mdri        = 1'b0;
    mdro        = 1'b0;
    mdr_read    = 1'b0;
    iri         = 1'b0;
    ryi         = 1'b0;
    zi          = 1'b0;
    zlowo       = 1'b0;
    co          = 1'b0;
    rd          = 1'b0;
    wr          = 1'b0;
    reg_out_en  = 1'b0;
    reg_in_en   = 1'b0;
    reg_out_sel = '0;
    reg_in_sel  = '0;
    alu_op      = ALU_PASS;
    halted      = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      S_T0: begin
        pco   = 1'b1;
        mari  = 1'b1;
        incpc = 1'b1;
        zi    = 1'b1;
      end
      S_T1: begin
        zlowo    = 1'b1;
        pci      = 1'b1;
        rd       = 1'b1;
        mdri     = 1'b1;
        mdr_read = 1'b1;
      end
      S_T2: begin
        mdro = 1'b1;
        iri  = 1'b1;
      end
      S_T3: begin
        case (cls)
          CL_RTYPE: begin
            reg_out_en  = 1'b1;
            reg_out_sel = REG_SEL_W'(rb);
            ryi         = 1'b1;
          end
          CL_LD, CL_ST: begin
            // rb=0 leaves the bus undriven so Y loads zero
            reg_out_en  = (rb != 4'd0);
            reg_out_sel = REG_SEL_W'(rb);
            ryi         = 1'b1;
          end
          CL_ILLEGAL: illegal = 1'b1;
          default: ;
        endcase
      end
      S_T4: begin
        zi = 1'b1;
        if (cls == CL_RTYPE) begin
          reg_out_en  = 1'b1;
          reg_out_sel = REG_SEL_W'(rc);
          alu_op      = alu_r;
        end else begin
          co     = 1'b1;
          alu_op = ALU_ADD;
        end
      end
      S_T5: begin
        zlowo = 1'b1;
        if (cls == CL_RTYPE) begin
          reg_in_en  = 1'b1;
          reg_in_sel = REG_SEL_W'(ra);
        end else begin
          mari = 1'b1;
        end
      end
      S_T6: begin
        mdri = 1'b1;
        if (cls == CL_LD) begin
          rd       = 1'b1;
          mdr_read = 1'b1;
        end else begin
          reg_out_en  = 1'b1;
          reg_out_sel = REG_SEL_W'(ra);
        end
      end
      S_T7: begin
        if (cls == CL_LD) begin
          mdro       = 1'b1;
          reg_in_en  = 1'b1;
          reg_in_sel = REG_SEL_W'(ra);
        end else begin
          wr = 1'b1;
        end
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: random instruction stream checked per cycle
// against a step-list model of each instruction's strobe sequence.
module tb_control_unit;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        run = 1'b0;
  logic [31:0] ir = '0;
  logic        mem_ready = 1'b0;
  logic pco, pci, incpc, mari, mdri, mdro, mdr_read, iri, ryi, zi;
  logic zlowo, co, rd, wr, reg_out_en, reg_in_en, halted, illegal;
  logic [3:0] reg_out_sel, reg_in_sel, alu_op;

  int checks = 0;
  int errors = 0;

  control_unit #(.DATA_W(32), .REG_SEL_W(4)) dut (
    .clock(clock), .clear(clear), .run(run), .ir(ir),
    .mem_ready(mem_ready),
    .pco(pco), .pci(pci), .incpc(incpc), .mari(mari),
    .mdri(mdri), .mdro(mdro), .mdr_read(mdr_read), .iri(iri),
    .ryi(ryi), .zi(zi), .zlowo(zlowo), .co(co), .rd(rd), .wr(wr),
    .reg_out_en(reg_out_en), .reg_in_en(reg_in_en),
    .reg_out_sel(reg_out_sel), .reg_in_sel(reg_in_sel),
    .alu_op(alu_op), .halted(halted), .illegal(illegal)
  );

  always #5 clock = ~clock;

  logic [29:0] obs;
  assign obs = {alu_op, reg_in_sel, reg_out_sel, illegal, halted,
                reg_in_en, reg_out_en, wr, rd, co, zlowo, zi, ryi,
                iri, mdr_read, mdro, mdri, mari, incpc, pci, pco};

  localparam logic [29:0] PCO    = 30'h1;
  localparam logic [29:0] PCI    = 30'h2;
  localparam logic [29:0] INCPC  = 30'h4;
  localparam logic [29:0] MARI   = 30'h8;
  localparam logic [29:0] MDRI   = 30'h10;
  localparam logic [29:0] MDRO   = 30'h20;
  localparam logic [29:0] MDRRD  = 30'h40;
  localparam logic [29:0] IRI    = 30'h80;
  localparam logic [29:0] RYI    = 30'h100;
  localparam logic [29:0] ZI     = 30'h200;
  localparam logic [29:0] ZLOWO  = 30'h400;
  localparam logic [29:0] CO     = 30'h800;
  localparam logic [29:0] RD     = 30'h1000;
  localparam logic [29:0] WR     = 30'h2000;
  localparam logic [29:0] ROUT   = 30'h4000;
  localparam logic [29:0] RIN    = 30'h8000;
  localparam logic [29:0] HALTED = 30'h10000;
  localparam logic [29:0] ILL    = 30'h20000;

  function automatic logic [29:0] osel(logic [3:0] r);
    return {8'd0, r, 18'd0};
  endfunction
  function automatic logic [29:0] isel(logic [3:0] r);
    return {4'd0, r, 22'd0};
  endfunction
  function automatic logic [29:0] alu(logic [3:0] a);
    return {a, 26'd0};
  endfunction

  typedef struct {
    string       tag;
    logic [29:0] e;
    logic [31:0] irv;
    logic        mr;
  } step_t;

  step_t q[$];

  task automatic check(input string tag, input logic [29:0] got,
                       input logic [29:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input string tag, input logic [29:0] e,
                      input logic [31:0] irv, input logic mr);
    step_t s;
    s.tag = tag;
    s.e   = e;
    s.irv = irv;
    s.mr  = mr;
    q.push_back(s);
  endtask

  // memory step: optional wait cycles with mem_ready low, then ready
  task automatic push_mem(input string tag, input logic [29:0] e,
                          input logic [31:0] irv);
    int w;
`ifdef CONTROL_UNIT_MEM_WAIT_EN
    w = $urandom_range(0, 3);
    repeat (w) push(tag, e, irv, 1'b0);
    push(tag, e, irv, 1'b1);
`else
    w = 0;
    push(tag, e, irv, 1'($urandom));
`endif
  endtask

  task automatic add_instr(input logic [31:0] i);
    logic [4:0]  op;
    logic [3:0]  ra, rb, rc;
    logic [31:0] junk;
    op   = i[31:27];
    ra   = i[26:23];
    rb   = i[22:19];
    rc   = i[18:15];
    junk = $urandom;
    push("T0", PCO | MARI | INCPC | ZI, i, 1'($urandom));
    push_mem("T1", ZLOWO | PCI | RD | MDRI | MDRRD, i);
    push("T2", MDRO | IRI, i, 1'($urandom));
    if (op >= 5'd3 && op <= 5'd10) begin
      push("R_T3", ROUT | osel(rb) | RYI, i, 1'($urandom));
      push("R_T4", ROUT | osel(rc) | alu(4'(op) - 4'd2) | ZI,
           junk, 1'($urandom));
      push("R_T5", ZLOWO | RIN | isel(ra), junk, 1'($urandom));
    end else if (op <= 5'd1) begin
      push("M_T3", ((rb != 4'd0) ? ROUT : 30'h0) | osel(rb) | RYI,
           i, 1'($urandom));
      push("M_T4", CO | alu(4'd1) | ZI, junk, 1'($urandom));
      push("M_T5", ZLOWO | MARI, junk, 1'($urandom));
      if (op == 5'd0) begin
        push_mem("LD_T6", RD | MDRI | MDRRD, junk);
        push("LD_T7", MDRO | RIN | isel(ra), junk, 1'($urandom));
      end else begin
        push("ST_T6", ROUT | osel(ra) | MDRI, junk, 1'($urandom));
        push_mem("ST_T7", WR, junk);
      end
    end else if (op == 5'd26) begin
      push("NOP_T3", 30'h0, i, 1'($urandom));
    end else if (op == 5'd27) begin
      push("HLT_T3", 30'h0, i, 1'($urandom));
    end else begin
      push("ILL_T3", ILL, i, 1'($urandom));
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [4:0]  op;
    int          k, v;
    r = $urandom;
    k = $urandom_range(0, 9);
    if (k <= 3) op = 5'($urandom_range(3, 10));
    else if (k == 4 || k == 9) op = 5'd0;
    else if (k == 5) op = 5'd1;
    else if (k == 6) op = 5'd26;
    else begin
      v  = $urandom_range(0, 18);
      op = (v < 15) ? 5'(11 + v) : 5'(28 + v - 15);
    end
    r[31:27] = op;
    if (k == 9) r[22:19] = 4'd0;
    return r;
  endfunction

  task automatic run_steps(input int n);
    step_t s;
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      s = q.pop_front();
      check(s.tag, obs, s.e);
      ir        = s.irv;
      mem_ready = s.mr;
      run       = 1'($urandom);
    end
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check("RST", obs, 30'h0);
    clear = 1'b0;
    repeat (2) begin
      @(negedge clock);
      check("IDLE", obs, 30'h0);
    end
    run = 1'b1;

    add_instr(32'h28918000);
    add_instr(32'h00800065);
    for (int k = 0; k < 60; k++) add_instr(rand_instr());
    run_steps(q.size());

    add_instr({5'($urandom_range(3, 10)), 27'($urandom)});
    run_steps(q.size() - 2);
    @(posedge clock);
    #2;
    check("PRE_CLR_T4", obs, q[0].e);
    clear = 1'b1;
    #1;
    check("CLR_ASYNC", obs, 30'h0);
    q.delete();
    run = 1'b0;
    @(negedge clock);
    check("CLR_HOLD", obs, 30'h0);
    clear = 1'b0;
    @(negedge clock);
    check("IDLE2", obs, 30'h0);
    run = 1'b1;

    add_instr({5'd27, 27'($urandom)});
    repeat (20) push("HALT", HALTED, $urandom, 1'($urandom));
    run_steps(q.size());

    clear = 1'b1;
    #1;
    check("HALT_CLR", obs, 30'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired control sequencer for the single-bus CPU datapath. It drives the datapath's per-register bus strobes (`*i` load enables, `*o` bus drivers) through fetch, decode and execute micro-steps, one step per clock. The sequence per instruction is T0–T7, chosen from the IR opcode. The block sits beside the datapath, with the IR contents as its only data input, and replaces bench-driven strobe sequencing.

## Interface
Parameters:
- `DATA_W`, default 32: IR/word width.
- `REG_SEL_W`, default 4: general-register select width (16 registers).

Ports:
- `clock` in 1: single system clock; all state changes on the rising edge.
- `clear` in 1: asynchronous, active-high reset.
- `run` in 1: start/continue execution; sampled only in IDLE.
- `ir` in DATA_W: current IR value from the datapath. Fields: opcode [31:27], ra [26:23], rb [22:19], rc [18:15], c [18:0].
- `mem_ready` in 1: memory handshake complete.
- `pco`, `pci`, `incpc` out 1: PC drive, PC load, PC increment.
- `mari`, `mdri`, `mdro`, `mdr_read` out 1: MAR/MDR strobes. `mdr_read`=1 selects memory over bus as the MDR source.
- `iri`, `ryi`, `zi`, `zlowo`, `co` out 1: IR load, Y load, Z load, Zlow drive, sign-extended C drive.
- `rd`, `wr` out 1: memory read and write requests.
- `reg_out_en`, `reg_in_en` out 1; `reg_out_sel`, `reg_in_sel` out REG_SEL_W: general-register drive/load with index.
- `alu_op` out 4: ALU function (PASS=0, ADD, SUB, AND, OR, SHR, SHL, ROR, ROL).
- `halted` out 1: high in HALT.
- `illegal` out 1: one-cycle pulse on an undefined opcode.

## Operation
- States: IDLE, T0–T7, HALT. Encodings live in the package.
- Outputs are Moore-decoded from state plus the registered IR fields. Every strobe not listed for a state is 0.
- IDLE: if `run`=1, go to T0; otherwise stay.
- T0: `pco mari incpc zi`.
- T1: `zlowo pci rd mdri mdr_read`.
- T2: `mdro iri`.
- T3: decode.
  - R-type (opcodes 00011–01010 = ADD SUB AND OR SHR SHL ROR ROL): T3 `reg_out_en` sel=rb, `ryi`. T4 `reg_out_en` sel=rc, `alu_op`=op, `zi`. T5 `zlowo reg_in_en` sel=ra. Then T0.
  - ld (00000): T3 rb→`ryi`; if rb=0 the Y input is 0 (base-zero addressing). T4 `co`, ADD, `zi`. T5 `zlowo mari`. T6 `rd mdri mdr_read`. T7 `mdro reg_in_en` sel=ra. Then T0.
  - st (00001): T3–T5 as ld. T6 `reg_out_en` sel=ra, `mdri`. T7 `wr`. Then T0.
  - nop (11010): T3 goes to T0.
  - halt (11011): T3 goes to HALT.
  - Any other opcode: `illegal` pulses in T3, then T0 (treated as nop).
- HALT holds, `halted`=1, until `clear`.
- ALU results are truncated to DATA_W, with no flags. `co` drives `{{13{c[18]}}, c}`.

## Timing
- `clear` asserted: state goes to IDLE immediately, and all outputs are 0 within the same cycle, including mid-instruction. No partial writeback completes.
- Every state lasts 1 cycle, except the memory states listed under Configuration.
- R-type: 6 cycles, T0 to next T0. ld/st: 8 cycles. nop/illegal: 4 cycles.
- The IR fields used in T3–T7 are those loaded at the T2 edge. The `ir` input is not re-decoded mid-instruction.
- `run` is ignored outside IDLE. Deasserting `run` mid-program has no effect.

## Configuration
- `CONTROL_UNIT_MEM_WAIT_EN` defined:
  - T1, ld T6 and st T7 hold, with strobes asserted, until `mem_ready`=1. They advance on the edge where `mem_ready`=1.
  - `mem_ready`=1 on the entry cycle gives zero extra cycles.
- Undefined: `mem_ready` is ignored and memory is single-cycle.

## Structure
- `cpu_pkg`: opcode constants, state enum, `alu_op` encodings, IR field bit positions.
- Sub-module `instr_decode`: combinational. Maps opcode to class (RTYPE/LD/ST/NOP/HALT/ILLEGAL) and to `alu_op`.

## Test plan
- `clear` pulse, then `run`=1: cycle 1 shows `pco mari incpc zi`=1 and everything else 0. Asserting `clear` in T4 returns all outputs to 0 asynchronously.
- IR=0x28918000 (and r1,r2,r3):
  - T3: `reg_out_sel`=2, `ryi`.
  - T4: `reg_out_sel`=3, `alu_op`=AND, `zi`.
  - T5: `reg_in_sel`=1, `zlowo`.
  - Next T0 on cycle 7.
- IR=0x00800065 (ld r1,0x65(r0)): T4 `co`=1, `alu_op`=ADD; T5 `mari`; T6 `rd mdri`; T7 `reg_in_sel`=1, `mdro`. 8 cycles total.
- With `CONTROL_UNIT_MEM_WAIT_EN`, `mem_ready` held low 3 cycles in T1: `rd mdri` stay high for 4 cycles, and T2 follows the ready edge.
- Opcode 11111: `illegal` pulses exactly once in T3, then T0. Opcode 11011: `halted`=1, and it stays in HALT for 20 cycles with `run` toggling.
